sprite_palette_bank: RTL



---
 rtl/sprite_palette_bank_if.sv | 39 +++
 rtl/sprite_palette_bank.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sprite_palette_bank_if.sv
// Lookup / write / control bundle for sprite_palette_bank.
// Ports:
//   master: drives rd_valid, index, bank_sel, frame_start, wr_en, wr_bank,
//           wr_index, wr_rgb and flash_trig. It receives red, green, blue,
//           out_valid, transparent, active_bank and flash_active.
//   slave : the palette bank side, with the directions reversed.
interface sprite_palette_bank_if #(
    parameter int unsigned INDEX_W = 3,
    parameter int unsigned BANK_W  = 2
);
    logic               rd_valid;
    logic [INDEX_W-1:0] index;
    logic [BANK_W-1:0]  bank_sel;
    logic               frame_start;
    logic               wr_en;
    logic [BANK_W-1:0]  wr_bank;
    logic [INDEX_W-1:0] wr_index;
    logic [11:0]        wr_rgb;
    logic               flash_trig;
    logic [3:0]         red;
    logic [3:0]         green;
    logic [3:0]         blue;
    logic               out_valid;
    logic               transparent;
    logic [BANK_W-1:0]  active_bank;
    logic               flash_active;

    modport master (
        output rd_valid, index, bank_sel, frame_start,
        output wr_en, wr_bank, wr_index, wr_rgb, flash_trig,
        input  red, green, blue, out_valid, transparent, active_bank, flash_active
    );

    modport slave (
        input  rd_valid, index, bank_sel, frame_start,
        input  wr_en, wr_bank, wr_index, wr_rgb, flash_trig,
        output red, green, blue, out_valid, transparent, active_bank, flash_active
    );
endinterface

// File: rtl/sprite_palette_bank.sv
// sprite_palette_bank: NUM_BANKS runtime-writable palettes of 2^INDEX_W
// 12-bit RGB (4:4:4) entries. The lookup result is registered one cycle
// after the request and carries a transparency flag. The active bank
// changes only on frame_start, so a sprite's palette can be swapped
// without tearing.
// Ports:
//   Clk, Reset_n : clock and asynchronous active-low reset
//   bus (slave)  : lookup request/result, palette write port, frame_start,
//                  bank select and flash trigger (see sprite_palette_bank_if)
// Optional feature: define SPRITE_PALETTE_FLASH_EN to build the hit-flash
// counter. While that counter is odd, non-transparent lookups return white.
module sprite_palette_bank #(
    parameter int unsigned INDEX_W         = 3,
    parameter int unsigned NUM_BANKS       = 4,
    parameter int unsigned BANK_W          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    parameter int unsigned TRANSPARENT_IDX = 0,
    parameter int unsigned FLASH_FRAMES    = 8
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    sprite_palette_bank_if.slave  bus
);

    localparam int unsigned ENTRIES = 1 << INDEX_W;
    localparam int unsigned RGB_W   = 12;

    // Power-up contents: the legacy fixed palette in bank 0. Everything else is black.
    function automatic logic [RGB_W-1:0] default_rgb(input int unsigned bank,
                                                     input int unsigned entry);
        logic [RGB_W-1:0] rgb;
        rgb = '0;
        if (bank == 0) begin
            case (entry)
                0:       rgb = 12'h0E0;
                1:       rgb = 12'h080;
                2:       rgb = 12'h04E;
                3:       rgb = 12'h977;
                4:       rgb = 12'hD30;
                5:       rgb = 12'hECA;
                6:       rgb = 12'h000;
                7:       rgb = 12'h026;
                default: rgb = 12'h000;
            endcase
        end
        return rgb;
    endfunction

    logic [RGB_W-1:0]  palette_q [NUM_BANKS][ENTRIES];
    logic [RGB_W-1:0]  palette_d [NUM_BANKS][ENTRIES];
    logic [BANK_W-1:0] active_bank_q, active_bank_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic              out_valid_q, out_valid_d;
    logic              transparent_q, transparent_d;

    logic              wr_ok;
    logic              is_transparent;
    logic [RGB_W-1:0]  lookup_rgb;
    logic              flash_odd;

    // Palette write. Out-of-range banks are dropped. The read below uses
    // palette_q, so a same-cycle lookup sees the old entry.
    always_comb begin : palette_next
        palette_d = palette_q;
        wr_ok     = bus.wr_en && (32'(bus.wr_bank) < NUM_BANKS);
        if (wr_ok) begin
            palette_d[bus.wr_bank][bus.wr_index] = bus.wr_rgb;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin : palette_regs
        if (!Reset_n) begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                for (int unsigned e = 0; e < ENTRIES; e++) begin
                    palette_q[BANK_W'(b)][INDEX_W'(e)] <= default_rgb(b, e);
                end
            end
        end else begin
            palette_q <= palette_d;
        end
    end

    // Bank switch only at frame start. An invalid request keeps the current bank.
    always_comb begin : bank_next
        active_bank_d = active_bank_q;
        if (bus.frame_start && (32'(bus.bank_sel) < NUM_BANKS)) begin
            active_bank_d = bus.bank_sel;
        end
    end

`ifdef SPRITE_PALETTE_FLASH_EN
    localparam int unsigned FLASH_CNT_W = (FLASH_FRAMES > 0) ? $clog2(FLASH_FRAMES + 1) : 1;

    logic [FLASH_CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic                   flash_active_q, flash_active_d;

    // A trigger reloads the counter even if it lands on a frame_start.
    always_comb begin : flash_next
        flash_cnt_d = flash_cnt_q;
        if (bus.flash_trig) begin
            flash_cnt_d = FLASH_CNT_W'(FLASH_FRAMES);
        end else if (bus.frame_start && (flash_cnt_q != '0)) begin
            flash_cnt_d = flash_cnt_q - FLASH_CNT_W'(1);
        end
        flash_active_d = (flash_cnt_d != '0);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin : flash_regs
        if (!Reset_n) begin
            flash_cnt_q    <= '0;
            flash_active_q <= 1'b0;
        end else begin
            flash_cnt_q    <= flash_cnt_d;
            flash_active_q <= flash_active_d;
        end
    end

    assign flash_odd        = flash_cnt_q[0];
    assign bus.flash_active = flash_active_q;
`else
    logic unused_flash;

    assign unused_flash     = ^{bus.flash_trig, 32'(FLASH_FRAMES)};
    assign flash_odd        = 1'b0;
    assign bus.flash_active = 1'b0;
`endif

    // Lookup. Idle cycles return black and are never transparent.
    always_comb begin : lookup_next
        lookup_rgb     = palette_q[active_bank_q][bus.index];
        is_transparent = (bus.index == INDEX_W'(TRANSPARENT_IDX));
        rgb_d          = '0;
        out_valid_d    = bus.rd_valid;
        transparent_d  = bus.rd_valid && is_transparent;
        if (bus.rd_valid) begin
            rgb_d = (flash_odd && !is_transparent) ? 12'hFFF : lookup_rgb;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin : out_regs
        if (!Reset_n) begin
            rgb_q         <= '0;
            out_valid_q   <= 1'b0;
            transparent_q <= 1'b0;
            active_bank_q <= '0;
        end else begin
            rgb_q         <= rgb_d;
            out_valid_q   <= out_valid_d;
            transparent_q <= transparent_d;
            active_bank_q <= active_bank_d;
        end
    end

    assign bus.red         = rgb_q[11:8];
    assign bus.green       = rgb_q[7:4];
    assign bus.blue        = rgb_q[3:0];
    assign bus.out_valid   = out_valid_q;
    assign bus.transparent = transparent_q;
    assign bus.active_bank = active_bank_q;

endmodule
